iecdrv_fastser: RTL and testbench
=================================

// Module: iecdrv_fastser
// PURPOSE
// - Parametrised fast-serial (burst) engine for 1571/1581-class drive models. It replaces the fixed 8-bit CIA SP/CNT path.
// - Sits between the drive CPU bus glue and the IEC DATA/FCLK open-drain lines.
// - TX and RX FIFOs let firmware or a burst accelerator stream bytes without per-byte polling.
// - Adds what the CIA path lacks: a configurable bit period, FIFO buffering, an RX inter-bit timeout and overflow reporting.
// PARAMETERS
// - DATA_W   8   bits per serial word, shifted MSB first (range 1..16)
// - FIFO_AW  3   log2 of each FIFO depth (depth = 2**FIFO_AW)
// - DIV_W    8   width of the half-bit divider register
// - TMO      255 RX inter-bit timeout, in ce ticks
// PORTS
// - clk        in   1       system clock; all logic is on its rising edge
// - reset_n    in   1       asynchronous, active-low reset
// - ce         in   1       timebase enable; all line timing counts ce ticks
// - fast_dir   in   1       1 = transmit (drive owns FCLK/DATA), 0 = receive
// - half_div   in   DIV_W   half-bit period, in ce ticks; 0 is treated as 1
// - tx_data    in   DATA_W  word to enqueue
// - tx_wr      in   1       enqueue strobe; ignored while the TX FIFO is full
// - tx_full    out  1       TX FIFO full
// - tx_empty   out  1       TX FIFO empty
// - rx_data    out  DATA_W  head of the RX FIFO (first-word fall-through)
// - rx_rd      in   1       dequeue strobe; ignored while the RX FIFO is empty
// - rx_empty   out  1       RX FIFO empty
// - rx_ovf     out  1       sticky: a received word was dropped; cleared by ovf_clr
// - ovf_clr    in   1       clears rx_ovf
// - busy       out  1       TX shifting or an RX word is partially received
// - irq        out  1       one-clk pulse per completed TX or RX word
// - fclk_i     in   1       FCLK line input (1 = released)
// - data_i     in   1       DATA line input (1 = released)
// - fclk_o     out  1       FCLK drive (0 = pull low)
// - data_o     out  1       DATA drive (0 = pull low)
// BEHAVIOUR
// - Reset values: fclk_o=1, data_o=1, irq=0, busy=0, rx_ovf=0, both FIFOs empty, TX FSM in IDLE, RX bit count 0.
// - Reset is async assert, sync release; it also aborts any word in flight.
// - fclk_i and data_i pass through a 2-FF synchroniser. RX edge detection uses the synchronised copies.
// - TX FSM states: IDLE, SETUP, LOW, HIGH.
//   - IDLE: if fast_dir=1 and TX FIFO not empty, pop the head into the shifter, set bit count to DATA_W, go to SETUP.
//   - SETUP: data_o = shifter MSB, fclk_o = 1. After half_div ce ticks go to LOW.
//   - LOW: fclk_o = 0. After half_div ce ticks go to HIGH.
//   - HIGH: fclk_o = 1; the receiver samples on this rising edge. After half_div ce ticks, shift left and decrement the count.
//     - count != 0: go to SETUP.
//     - count == 0: pulse irq and go to IDLE. data_o returns to 1 on that IDLE entry.
// - TX word time = 3*half_div*DATA_W ce ticks. Back-to-back words have no extra gap beyond the IDLE->SETUP clk.
// - fast_dir dropping to 0 mid-word: the TX FSM goes to IDLE on the next clk, fclk_o=data_o=1, and the partial word is discarded (not re-queued).
// - While fast_dir=0, fclk_o=1 and data_o=1 always (lines released).
// - RX is active only while fast_dir=0.
//   - On each synchronised fclk_i rising edge, shift data_i into the LSB and increment the bit count.
//   - At DATA_W bits: push to the RX FIFO (or set rx_ovf and drop the word if full), pulse irq, clear the count.
//   - A push and an rx_rd in the same clk are both honoured when the FIFO is full.
// - RX timeout: with count != 0 and no fclk_i rising edge for TMO ce ticks, the partial word is discarded and the count cleared. No irq, no rx_ovf.
// - fast_dir rising to 1 also clears any partial RX word.
// - FIFOs: pointer width FIFO_AW+1; full/empty derive from the pointer MSB compare. Simultaneous write and read on a non-full, non-empty FIFO leaves the count unchanged.
// - busy = (TX FSM != IDLE) | (RX count != 0).
// - irq is never stretched. If a TX and an RX completion occur in the same clk, which cannot legitimately happen, a single pulse is issued.
// TESTING
// - T1: reset_n=0 mid-TX -> fclk_o=data_o=1, busy=0, tx_empty=1 asynchronously. Idle state after release.
// - T2: fast_dir=1, half_div=2, ce=1, write 8'hA5 -> fclk_o shows 8 low pulses of 2 clks each, total 48 clks.
//   - data_o during each HIGH phase reads 1,0,1,0,0,1,0,1. One irq pulse, tx_empty=1.
// - T3: fast_dir=0, drive fclk_i/data_i with 8'h3C MSB first -> after the 8th rising edge plus 3 clks, rx_data=8'h3C, rx_empty=0, irq pulse.
// - T4: depth 8 with RX FIFO full, send a 9th word -> rx_ovf=1 and the FIFO contents are unchanged. ovf_clr -> rx_ovf=0.
// - T5: send 5 RX bits, then hold fclk_i high for TMO+4 ce ticks, then send 8'h81 -> only 8'h81 is queued, no overflow.
// - T6: write 3 TX words, drop fast_dir after the 4th bit of word 1 -> lines released within 1 clk, tx FIFO still holds 2 words.
//   - Raising fast_dir again sends word 2 intact.

Source files
------------

// File: rtl/iecdrv_fastser.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_fastser
// Purpose  : Fast-serial burst engine with TX/RX FIFOs for the IEC DATA/FCLK lines.
// Revision : 1.0 - initial release
// ============================================================================
module iecdrv_fastser #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 8,
    parameter int TMO     = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              fast_dir,
    input  logic [DIV_W-1:0]  half_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_empty,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_rd,
    output logic              rx_empty,
    output logic              rx_ovf,
    input  logic              ovf_clr,
    output logic              busy,
    output logic              irq,
    input  logic              fclk_i,
    input  logic              data_i,
    output logic              fclk_o,
    output logic              data_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH} tx_state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic [1:0] r_fclk_s, r_data_s;
    logic       r_fclk_prev;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fclk_s    <= 2'b11;
            r_data_s    <= 2'b11;
            r_fclk_prev <= 1'b1;
        end else begin
            r_fclk_s    <= {r_fclk_s[0], fclk_i};
            r_data_s    <= {r_data_s[0], data_i};
            r_fclk_prev <= r_fclk_s[1];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] r_tx_mem [DEPTH];
    logic [FIFO_AW:0]  r_tx_wp, r_tx_rp;
    logic              w_tx_push, w_tx_pop;
    tx_state_t         r_state;

    assign tx_empty  = (r_tx_wp == r_tx_rp);
    assign tx_full   = (r_tx_wp[FIFO_AW] != r_tx_rp[FIFO_AW]) &&
                       (r_tx_wp[FIFO_AW-1:0] == r_tx_rp[FIFO_AW-1:0]);
    assign w_tx_push = tx_wr & ~tx_full;
    assign w_tx_pop  = fast_dir & (r_state == S_IDLE) & ~tx_empty;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    logic [DATA_W-1:0] r_tx_sh, w_tx_sh_next;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [DIV_W-1:0]  r_tcnt, w_half;
    logic              w_tick_end, w_tx_fin;

    assign w_half       = (half_div == '0) ? DIV_W'(1) : half_div;
    assign w_tick_end   = ce & (r_tcnt == w_half - DIV_W'(1));
    assign w_tx_sh_next = r_tx_sh << 1;
    assign w_tx_fin     = fast_dir & (r_state == S_HIGH) & w_tick_end &
                          (r_tx_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= S_IDLE;
            r_tx_sh  <= '0;
            r_tx_cnt <= '0;
            r_tcnt   <= '0;
            fclk_o   <= 1'b1;
            data_o   <= 1'b1;
        end else if (!fast_dir) begin
            // Leaving transmit mode abandons the word in flight and frees the lines.
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            fclk_o  <= 1'b1;
            data_o  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    fclk_o <= 1'b1;
                    data_o <= 1'b1;
                    if (!tx_empty) begin
                        r_tx_sh  <= r_tx_mem[r_tx_rp[FIFO_AW-1:0]];
                        r_tx_cnt <= CNT_W'(DATA_W);
                        data_o   <= r_tx_mem[r_tx_rp[FIFO_AW-1:0]][DATA_W-1];
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tick_end) begin
                        r_tcnt  <= '0;
                        fclk_o  <= 1'b0;
                        r_state <= S_LOW;
                    end else if (ce) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (w_tick_end) begin
                        r_tcnt  <= '0;
                        fclk_o  <= 1'b1;
                        r_state <= S_HIGH;
                    end else if (ce) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    if (w_tick_end) begin
                        r_tcnt   <= '0;
                        r_tx_sh  <= w_tx_sh_next;
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                        if (r_tx_cnt == CNT_W'(1)) begin
                            data_o  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            data_o  <= w_tx_sh_next[DATA_W-1];
                            r_state <= S_SETUP;
                        end
                    end else if (ce) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX shifter and FIFO ----------------
    logic [DATA_W-1:0] r_rx_mem [DEPTH];
    logic [FIFO_AW:0]  r_rx_wp, r_rx_rp;
    logic [DATA_W-1:0] r_rx_sh, w_rx_word;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              w_rise, w_rx_fin, w_rx_rd, w_rx_push, rx_full;

    assign rx_empty  = (r_rx_wp == r_rx_rp);
    assign rx_full   = (r_rx_wp[FIFO_AW] != r_rx_rp[FIFO_AW]) &&
                       (r_rx_wp[FIFO_AW-1:0] == r_rx_rp[FIFO_AW-1:0]);
    assign rx_data   = r_rx_mem[r_rx_rp[FIFO_AW-1:0]];
    assign w_rise    = r_fclk_s[1] & ~r_fclk_prev;
    assign w_rx_word = (r_rx_sh << 1) | DATA_W'(r_data_s[1]);
    assign w_rx_fin  = ~fast_dir & w_rise & (r_rx_cnt == CNT_W'(DATA_W - 1));
    assign w_rx_rd   = rx_rd & ~rx_empty;
    // A concurrent read frees the slot, so a full FIFO still accepts the word.
    assign w_rx_push = w_rx_fin & (~rx_full | w_rx_rd);

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_AW-1:0]] <= w_rx_word;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_sh  <= '0;
            r_rx_cnt <= '0;
            r_tmo    <= '0;
            rx_ovf   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= w_tx_fin | w_rx_fin;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_rd)   r_rx_rp <= r_rx_rp + 1'b1;
            if (w_rx_fin && !w_rx_push) rx_ovf <= 1'b1;
            else if (ovf_clr)           rx_ovf <= 1'b0;

            if (fast_dir) begin
                r_rx_cnt <= '0;
                r_tmo    <= '0;
            end else if (w_rise) begin
                r_tmo    <= '0;
                r_rx_sh  <= w_rx_word;
                r_rx_cnt <= w_rx_fin ? '0 : r_rx_cnt + 1'b1;
            end else if (r_rx_cnt != '0 && ce) begin
                if (r_tmo == TMO_W'(TMO - 1)) begin
                    r_rx_cnt <= '0;
                    r_tmo    <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign busy = (r_state != S_IDLE) | (r_rx_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_iecdrv_fastser.sv
`default_nettype none
// Scoreboard bench for iecdrv_fastser: line-level TX decoder and RX sender
// compared against queues of expected words and irq counts.
module tb_iecdrv_fastser;
    localparam int DW   = 8;
    localparam int TMO  = 255;

    logic          clk = 1'b0;
    logic          reset_n, ce, fast_dir, tx_wr, rx_rd, ovf_clr, fclk_i, data_i;
    logic [7:0]    half_div;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_full, tx_empty, rx_empty, rx_ovf, busy, irq, fclk_o, data_o;

    iecdrv_fastser #(.DATA_W(DW), .FIFO_AW(3), .DIV_W(8), .TMO(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .fast_dir(fast_dir), .half_div(half_div),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_ovf(rx_ovf),
        .ovf_clr(ovf_clr), .busy(busy), .irq(irq), .fclk_i(fclk_i), .data_i(data_i),
        .fclk_o(fclk_o), .data_o(data_o)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0, n_err = 0;
    int            irq_cnt = 0, exp_irq = 0, tx_nb = 0;
    logic [DW-1:0] exp_tx[$], exp_rx[$];
    logic [DW-1:0] tx_acc;
    logic          fclk_prev_o = 1'b1;
    bit            mon_rx_en = 1'b1, ce_rand = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1 ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // TX line decoder: data_o is captured at each FCLK rising edge.
    initial forever begin
        @(negedge clk);
        if (irq === 1'b1) irq_cnt++;
        if (reset_n !== 1'b1 || fast_dir !== 1'b1) begin
            tx_nb = 0;
        end else if (fclk_prev_o === 1'b0 && fclk_o === 1'b1) begin
            tx_acc = {tx_acc[DW-2:0], data_o};
            tx_nb++;
            if (tx_nb == DW) begin
                tx_nb = 0;
                if (exp_tx.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_acc);
                end else begin
                    check("tx_word", tx_acc, exp_tx.pop_front());
                end
            end
        end
        fclk_prev_o = fclk_o;
    end

    // RX drain: compare the FIFO head and pop it.
    initial begin
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            rx_rd = 1'b0;
            if (mon_rx_en && reset_n === 1'b1 && rx_empty === 1'b0) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    check("rx_word", rx_data, exp_rx.pop_front());
                end
                rx_rd = 1'b1;
            end
        end
    end

    task automatic tx_write(logic [DW-1:0] w);
        tx_data = w;
        tx_wr   = 1'b1;
        clks(1);
        tx_wr   = 1'b0;
        exp_tx.push_back(w);
        exp_irq++;
    endtask

    task automatic rx_send(logic [DW-1:0] w, int nbits, int h);
        for (int i = DW - 1; i >= DW - nbits; i--) begin
            data_i = w[i];
            fclk_i = 1'b0;
            clks(h);
            fclk_i = 1'b1;
            clks(h);
        end
    endtask

    task automatic wait_tx_done(string name, int budget);
        int k = 0;
        while (!(tx_empty && !busy && exp_tx.size() == 0) && k < budget) begin
            clks(1);
            k++;
        end
        check(name, (k < budget), 1);
        clks(2);
    endtask

    task automatic wait_rx_drain(string name, int budget);
        int k = 0;
        while (exp_rx.size() != 0 && k < budget) begin
            clks(1);
            k++;
        end
        check(name, (k < budget), 1);
        clks(2);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nl, np, n;
        logic pl;
        logic [DW-1:0] w;
        reset_n = 1'b1; fast_dir = 1'b0; half_div = 8'd2; tx_data = '0; tx_wr = 1'b0;
        ovf_clr = 1'b0; fclk_i = 1'b1; data_i = 1'b1;
        #2 reset_n = 1'b0;
        clks(3);
        check("rst_fclk_o", fclk_o, 1);
        check("rst_data_o", data_o, 1);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_ovf", rx_ovf, 0);
        check("rst_empties", {tx_empty, rx_empty}, 2'b11);
        reset_n = 1'b1;
        clks(4);

        // T1: reset while a word is being shifted out
        fast_dir = 1'b1;
        tx_write(8'h5A);
        clks(10);
        check("t1_busy_mid", busy, 1);
        #3 reset_n = 1'b0;
        #1;
        check("t1_async_lines", {fclk_o, data_o}, 2'b11);
        check("t1_async_busy", busy, 0);
        check("t1_async_tx_empty", tx_empty, 1);
        exp_tx.delete();
        exp_irq--;
        clks(2);
        reset_n = 1'b1;
        clks(4);
        check("t1_idle_after", {busy, fclk_o, data_o, tx_empty}, 4'b0111);

        // T2: A5 at half_div=2, ce always on
        half_div = 8'd2;
        tx_write(8'hA5);
        nb = 0; nl = 0; np = 0; pl = 1'b1;
        repeat (60) begin
            clks(1);
            if (busy) nb++;
            if (!fclk_o) nl++;
            if (pl && !fclk_o) np++;
            pl = fclk_o;
        end
        check("t2_busy_clks", nb, 48);
        check("t2_low_clks", nl, 16);
        check("t2_low_pulses", np, 8);
        wait_tx_done("t2_done", 200);
        check("t2_irq", irq_cnt, exp_irq);

        // T3: receive 3C; word appears 3 clks after the final FCLK rise
        fast_dir = 1'b0;
        mon_rx_en = 1'b0;
        rx_send(8'h3C, 8, 3);
        check("t3_rx_empty", rx_empty, 0);
        check("t3_rx_data", rx_data, 8'h3C);
        exp_rx.push_back(8'h3C);
        exp_irq++;
        mon_rx_en = 1'b1;
        wait_rx_drain("t3_drain", 50);
        check("t3_irq", irq_cnt, exp_irq);

        // T4: fill the RX FIFO, overflow with a ninth word
        mon_rx_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = DW'($urandom);
            rx_send(w, 8, 2);
            exp_rx.push_back(w);
            exp_irq++;
        end
        clks(3);
        check("t4_no_ovf_yet", rx_ovf, 0);
        rx_send(DW'($urandom), 8, 2);
        exp_irq++;
        clks(2);
        check("t4_ovf_set", rx_ovf, 1);
        ovf_clr = 1'b1;
        clks(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", rx_ovf, 0);
        mon_rx_en = 1'b1;
        wait_rx_drain("t4_drain", 50);
        check("t4_irq", irq_cnt, exp_irq);

        // T5: partial word times out, next word arrives clean
        rx_send(DW'($urandom), 5, 2);
        check("t5_busy_partial", busy, 1);
        clks(TMO + 4);
        check("t5_busy_timeout", busy, 0);
        rx_send(8'h81, 8, 2);
        exp_rx.push_back(8'h81);
        exp_irq++;
        clks(3);
        wait_rx_drain("t5_drain", 50);
        check("t5_ovf", rx_ovf, 0);
        check("t5_irq", irq_cnt, exp_irq);

        // T6: abort word 1 after its fourth bit, then resume
        fast_dir = 1'b1;
        half_div = 8'd2;
        tx_write(DW'($urandom));
        tx_write(DW'($urandom));
        tx_write(DW'($urandom));
        n = 0;
        while (tx_nb != 4 && n < 400) begin
            clks(1);
            n++;
        end
        check("t6_reach_bit4", (n < 400), 1);
        fast_dir = 1'b0;
        void'(exp_tx.pop_front());
        exp_irq--;
        clks(1);
        check("t6_lines_released", {fclk_o, data_o, busy}, 3'b110);
        check("t6_fifo_kept", tx_empty, 0);
        clks(5);
        fast_dir = 1'b1;
        wait_tx_done("t6_done", 400);
        check("t6_irq", irq_cnt, exp_irq);

        // Randomised traffic in both directions with a bursty ce
        ce_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            half_div = 8'($urandom_range(0, 3));
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 1) begin
                fast_dir = 1'b1;
                for (int k = 0; k < n; k++) tx_write(DW'($urandom));
                wait_tx_done("rnd_tx_done", 5000);
            end else begin
                fast_dir = 1'b0;
                for (int k = 0; k < n; k++) begin
                    w = DW'($urandom);
                    rx_send(w, 8, $urandom_range(1, 4));
                    exp_rx.push_back(w);
                    exp_irq++;
                end
                wait_rx_drain("rnd_rx_drain", 100);
            end
            check("rnd_irq", irq_cnt, exp_irq);
        end
        check("end_ovf", rx_ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
